// File: rtl/spike_encoder.sv
// Rate-coded spike generator: per-channel phase accumulators emit rate/2^RATE_W spikes per cycle over a fixed window.
// Spikes registered, latency 1 from the update edge; config is held off (cfg_ready low) outside IDLE, never queued.
module spike_encoder #(
  parameter int NUM_CH = 8,
  parameter int RATE_W = 8,
  parameter int WINDOW = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [2:0]        i_cfg_ch,
  input  logic [RATE_W-1:0] i_cfg_rate,
  input  logic              i_cfg_inhib,
  input  logic              i_start,
  input  logic              i_stop,
  output logic              o_busy,
  output logic              o_done,
  output logic [NUM_CH-1:0] o_excitatory,
  output logic [NUM_CH-1:0] o_inhibitory
);

  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  win_cnt;
  logic [RATE_W-1:0] rate_q [NUM_CH];
  logic [RATE_W-1:0] acc_q  [NUM_CH];
  logic [RATE_W:0]   sum    [NUM_CH];
  logic [NUM_CH-1:0] inhib_q;
  logic [NUM_CH-1:0] spike;
  logic              cfg_fire;
  logic              win_end;

  assign o_cfg_ready = (state == IDLE);
  assign o_busy      = (state == RUN);
  assign o_done      = (state == DONE);
  assign cfg_fire    = i_cfg_valid && o_cfg_ready;
  assign win_end     = (win_cnt == CNT_W'(WINDOW - 1));

  // The carry out of the accumulator is the spike: exactly floor(n*rate/2^RATE_W) carries after n updates from 0.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i]   = {1'b0, acc_q[i]} + {1'b0, rate_q[i]};
      spike[i] = sum[i][RATE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      win_cnt      <= '0;
      inhib_q      <= '0;
      o_excitatory <= '0;
      o_inhibitory <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        rate_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      o_excitatory <= '0;
      o_inhibitory <= '0;
      if (cfg_fire) begin
        rate_q[i_cfg_ch]  <= i_cfg_rate;
        inhib_q[i_cfg_ch] <= i_cfg_inhib;
      end
      case (state)
        IDLE: begin
          if (i_start) begin
            state   <= RUN;
            win_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
          end
        end
        RUN: begin
          // Abort wins over window end and leaves the accumulators untouched.
          if (i_stop) begin
            state <= IDLE;
          end else begin
            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= sum[i][RATE_W-1:0];
            o_excitatory <= spike & ~inhib_q;
            o_inhibitory <= spike & inhib_q;
            win_cnt      <= win_cnt + CNT_W'(1);
            if (win_end) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_encoder.sv
// Directed bench for spike_encoder: per-window spike counts, first-spike positions and handshake timing.
module tb_spike_encoder;

  localparam int W = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_cfg_valid = 1'b0;
  logic       o_cfg_ready;
  logic [2:0] i_cfg_ch = '0;
  logic [7:0] i_cfg_rate = '0;
  logic       i_cfg_inhib = 1'b0;
  logic       i_start = 1'b0;
  logic       i_stop = 1'b0;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_excitatory;
  logic [7:0] o_inhibitory;

  spike_encoder #(.NUM_CH(8), .RATE_W(8), .WINDOW(W)) dut (
    .clk(clk), .reset(reset),
    .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
    .i_cfg_ch(i_cfg_ch), .i_cfg_rate(i_cfg_rate), .i_cfg_inhib(i_cfg_inhib),
    .i_start(i_start), .i_stop(i_stop),
    .o_busy(o_busy), .o_done(o_done),
    .o_excitatory(o_excitatory), .o_inhibitory(o_inhibitory)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int exc_cnt [8];
  int inh_cnt [8];
  int first_exc [8];
  int first_inh [8];
  int both_hi;
  int done_early;
  int ch0_pattern_dev;
  int total;
  int stop_cnt;
  int stray_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] ch, input logic [7:0] rate, input logic inh);
    i_cfg_valid = 1'b1; i_cfg_ch = ch; i_cfg_rate = rate; i_cfg_inhib = inh;
    tick();
    i_cfg_valid = 1'b0;
  endtask

  task automatic run_window(input bit cfg_with_start, input logic [2:0] c_ch, input logic [7:0] c_rate,
                            input logic c_inh, input bit cfg_in_run);
    for (int c = 0; c < 8; c++) begin
      exc_cnt[c] = 0; inh_cnt[c] = 0; first_exc[c] = 0; first_inh[c] = 0;
    end
    both_hi = 0; done_early = 0; ch0_pattern_dev = 0;
    i_start = 1'b1;
    if (cfg_with_start) begin
      i_cfg_valid = 1'b1; i_cfg_ch = c_ch; i_cfg_rate = c_rate; i_cfg_inhib = c_inh;
    end
    tick();  // E0
    i_start = 1'b0;
    i_cfg_valid = 1'b0;
    chk("busy_after_e0", 32'(o_busy), 32'd1);
    chk("ready_after_e0", 32'(o_cfg_ready), 32'd0);
    for (int k = 1; k <= W; k++) begin
      if (cfg_in_run && k == 5) begin
        i_cfg_valid = 1'b1; i_cfg_ch = c_ch; i_cfg_rate = c_rate; i_cfg_inhib = c_inh;
        chk("ready_during_run", 32'(o_cfg_ready), 32'd0);
      end
      tick();  // Ek
      i_cfg_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
        if (o_excitatory[c]) begin
          exc_cnt[c]++;
          if (first_exc[c] == 0) first_exc[c] = k;
        end
        if (o_inhibitory[c]) begin
          inh_cnt[c]++;
          if (first_inh[c] == 0) first_inh[c] = k;
        end
        if (o_excitatory[c] && o_inhibitory[c]) both_hi++;
      end
      if (o_excitatory[0] != ((k % 2) == 0)) ch0_pattern_dev++;
      if (k < W && o_done) done_early++;
    end
    chk("done_after_ew", 32'(o_done), 32'd1);
    chk("busy_after_ew", 32'(o_busy), 32'd0);
    chk("done_early", 32'(done_early), 32'd0);
    tick();  // E(W+1)
    chk("done_cleared", 32'(o_done), 32'd0);
    chk("ready_after_window", 32'(o_cfg_ready), 32'd1);
    chk("exc_zero_after_window", 32'(o_excitatory), 32'd0);
    chk("inh_zero_after_window", 32'(o_inhibitory), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    reset = 1'b1;
    chk("rst_exc", 32'(o_excitatory), 32'd0);
    chk("rst_inh", 32'(o_inhibitory), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_ready", 32'(o_cfg_ready), 32'd1);

    // Default rates: silent window
    run_window(1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
    total = 0;
    for (int c = 0; c < 8; c++) total += exc_cnt[c] + inh_cnt[c];
    chk("default_total_spikes", 32'(total), 32'd0);

    // Mixed rates: 128 excit, 1 inhib, 255 excit
    cfg_write(3'd0, 8'd128, 1'b0);
    cfg_write(3'd1, 8'd1, 1'b1);
    cfg_write(3'd7, 8'd255, 1'b0);
    run_window(1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
    chk("ch0_exc_cnt", 32'(exc_cnt[0]), 32'd128);
    chk("ch0_first", 32'(first_exc[0]), 32'd2);
    chk("ch0_even_pattern", 32'(ch0_pattern_dev), 32'd0);
    chk("ch0_inh_cnt", 32'(inh_cnt[0]), 32'd0);
    chk("ch1_inh_cnt", 32'(inh_cnt[1]), 32'd1);
    chk("ch1_first", 32'(first_inh[1]), 32'd256);
    chk("ch1_exc_cnt", 32'(exc_cnt[1]), 32'd0);
    chk("ch7_exc_cnt", 32'(exc_cnt[7]), 32'd255);
    chk("ch7_first", 32'(first_exc[7]), 32'd2);
    chk("ch2_exc_cnt", 32'(exc_cnt[2]), 32'd0);
    chk("both_lines_high", 32'(both_hi), 32'd0);

    // Config attempt during RUN is ignored
    run_window(1'b0, 3'd0, 8'd3, 1'b1, 1'b1);
    chk("run_cfg_ch0_exc", 32'(exc_cnt[0]), 32'd128);
    run_window(1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
    chk("next_win_ch0_exc", 32'(exc_cnt[0]), 32'd128);
    chk("next_win_ch0_inh", 32'(inh_cnt[0]), 32'd0);
    chk("next_win_ch1_inh", 32'(inh_cnt[1]), 32'd1);
    chk("next_win_ch7_exc", 32'(exc_cnt[7]), 32'd255);

    // Config write in the same cycle as start
    run_window(1'b1, 3'd3, 8'd64, 1'b0, 1'b0);
    chk("ch3_exc_cnt", 32'(exc_cnt[3]), 32'd64);
    chk("ch3_first", 32'(first_exc[3]), 32'd4);
    chk("ch3_inh_cnt", 32'(inh_cnt[3]), 32'd0);

    // Abort sampled at E11: updates 1..10 visible, ch0 spikes at 2,4,6,8,10
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    stop_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      stop_cnt += int'(o_excitatory[0]);
    end
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    chk("stop_ch0_cnt", 32'(stop_cnt), 32'd5);
    chk("stop_busy", 32'(o_busy), 32'd0);
    chk("stop_ready", 32'(o_cfg_ready), 32'd1);
    chk("stop_exc", 32'(o_excitatory), 32'd0);
    chk("stop_inh", 32'(o_inhibitory), 32'd0);
    stray_done = int'(o_done);
    repeat (4) begin
      tick();
      stray_done += int'(o_done) + int'(o_excitatory != 0);
    end
    chk("stop_no_done", 32'(stray_done), 32'd0);
    run_window(1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
    chk("restart_ch0_exc", 32'(exc_cnt[0]), 32'd128);

    // Reset sampled at E50 of a running window
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (49) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_ready", 32'(o_cfg_ready), 32'd1);
    chk("midrst_done", 32'(o_done), 32'd0);
    chk("midrst_exc", 32'(o_excitatory), 32'd0);
    chk("midrst_inh", 32'(o_inhibitory), 32'd0);
    run_window(1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
    total = 0;
    for (int c = 0; c < 8; c++) total += exc_cnt[c] + inh_cnt[c];
    chk("midrst_rates_lost", 32'(total), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
